// File: rtl/sram_ctrl_pkg.sv
// Shared types, constants and address translation for the SRAM controller.
// Imported by the interface, the wait counter and the top level.
package sram_ctrl_pkg;

    localparam int SRAM_AW = 17;
    localparam int SRAM_DW = 32;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Full word offset from the base; the low two address bits are dropped.
    function automatic logic [29:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        logic [31:0] off;
        off = addr - base;
        return off[31:2];
    endfunction

    // SRAM word address: word offset truncated to the SRAM address width.
    function automatic logic [SRAM_AW-1:0] xlate(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        logic [29:0] w;
        w = word_index(addr, base);
        return w[SRAM_AW-1:0];
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: requests in, load data and ready out.
// master = pipeline, slave = controller. err exists only with SRAM_CTRL_RANGE_CHECK_EN.
interface sram_controller_if;
    import sram_ctrl_pkg::*;

    logic               wr_en;
    logic               rd_en;
    logic [31:0]        address;
    logic [SRAM_DW-1:0] wdata;
    logic [SRAM_DW-1:0] rdata;
    logic               ready;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic               err;

    modport master (
        output wr_en, rd_en, address, wdata,
        input  rdata, ready, err
    );
    modport slave (
        input  wr_en, rd_en, address, wdata,
        output rdata, ready, err
    );
`else
    modport master (
        output wr_en, rd_en, address, wdata,
        input  rdata, ready
    );
    modport slave (
        input  wr_en, rd_en, address, wdata,
        output rdata, ready
    );
`endif

endinterface

// File: rtl/sram_wait_counter.sv
// Wait-state counter: cleared by load or rst, counts up while en is high.
// Ports: clk, rst, load, en in; tc out (high when count == MAX-1).
module sram_wait_counter #(
    parameter int unsigned MAX = 5,
    parameter int          CW  = $clog2(MAX) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(MAX - 1));

endmodule

// File: rtl/sram_controller.sv
// Single-word load/store bridge from the MEM stage to an async SRAM with wait states.
// Ports: clk, rst (sync, active-high), bus (slave: wr_en, rd_en, address, wdata,
// rdata, ready[, err]), SRAM_ADDR, SRAM_WE_N, SRAM_DQ (inout).
// Optional macro SRAM_CTRL_RANGE_CHECK_EN drops out-of-range requests and flags err.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned DEPTH       = 512
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

    generate
        if (WAIT_CYCLES == 0) begin : g_bad_wait
            $error("sram_controller: WAIT_CYCLES must be at least 1");
        end
    endgenerate

    state_t state, state_n;

    logic               req;
    logic               req_ok;
    logic               tc;
    logic               cnt_load;
    logic               cnt_en;
    logic               dq_oe;
    logic               wr_q;
    logic               ok_q;
    logic [SRAM_DW-1:0] wdata_q;
    logic [SRAM_DW-1:0] rdata_q;

    assign req = bus.wr_en | bus.rd_en;

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic [29:0] req_word;
    logic        err_q;

    assign req_word = word_index(bus.address, BASE_ADDR);
    assign req_ok   = (bus.address >= BASE_ADDR) && (req_word < 30'(DEPTH));

    // err marks the DONE cycle of a dropped request only.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == ACCESS) && tc && !ok_q;
        end
    end

    assign bus.err = err_q;
`else
    assign req_ok = 1'b1;
`endif

    sram_wait_counter #(
        .MAX (WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .tc   (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        dq_oe     = 1'b0;
        bus.ready = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_load  = 1'b1;
                bus.ready = !req;
                if (req) begin
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                cnt_en = 1'b1;
                dq_oe  = wr_q && ok_q;
                if (tc) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                bus.ready = 1'b1;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Request capture in IDLE; read data capture on the final ACCESS edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            wr_q      <= 1'b0;
            ok_q      <= 1'b1;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == IDLE && req) begin
                SRAM_ADDR <= xlate(bus.address, BASE_ADDR);
                wdata_q   <= bus.wdata;
                wr_q      <= bus.wr_en;
                ok_q      <= req_ok;
                SRAM_WE_N <= !(bus.wr_en && req_ok);
            end
            if (state == ACCESS && tc) begin
                SRAM_WE_N <= 1'b1;
                if (!wr_q) begin
                    rdata_q <= ok_q ? SRAM_DQ : '0;
                end
            end
        end
    end

    assign SRAM_DQ   = dq_oe ? wdata_q : 'z;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural SRAM on the DQ bus.
// Directed steps then random load/stores against a word-level reference model.
module tb_sram_controller;

    localparam int W = 5;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int DEP = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] sram_addr;
    logic        sram_we_n;
    wire  [31:0] sram_dq;

    int checks = 0;
    int errors = 0;

    sram_controller_if bus_if ();

    sram_controller #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE),
        .DEPTH       (DEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_DQ   (sram_dq)
    );

    always #5 clk = ~clk;

    // SRAM model: drives DQ whenever not being written, latches on writes.
    logic [31:0] sram_mem [0:DEP-1];
    assign sram_dq = sram_we_n ? sram_mem[sram_addr[8:0]] : 32'bz;
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[8:0]] <= sram_dq;
    end

    // Reference model state
    logic [31:0] exp_mem [0:DEP-1];
    logic [31:0] exp_rdata = 32'd0;
    int          written[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request: W+1 frozen cycles then one DONE cycle.
    task automatic do_op(input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        logic [29:0] wfull;
        logic        in_rng;
        logic        issued;
        logic        is_rd;
        off    = addr - BASE;
        wfull  = off[31:2];
        in_rng = (addr >= BASE) && (wfull < 30'(DEP));
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        issued = in_rng;
`else
        issued = 1'b1;
`endif
        is_rd = !wr && rd;
        @(negedge clk);
        bus_if.wr_en   = wr;
        bus_if.rd_en   = rd;
        bus_if.address = addr;
        bus_if.wdata   = data;
        #1;
        chk("ready_c0", 32'(bus_if.ready), 32'd0);
        for (int c = 1; c <= W; c++) begin
            @(negedge clk); #1;
            chk("ready_acc", 32'(bus_if.ready), 32'd0);
            chk("we_n_acc", 32'(sram_we_n), 32'(!(wr && issued)));
            chk("addr_acc", 32'(sram_addr), 32'(wfull[16:0]));
`ifdef SRAM_CTRL_RANGE_CHECK_EN
            chk("err_acc", 32'(bus_if.err), 32'd0);
`endif
        end
        if (wr && issued && in_rng) begin
            exp_mem[wfull[8:0]] = data;
            written.push_back(int'(wfull[8:0]));
        end
        if (is_rd) exp_rdata = (issued && in_rng) ? exp_mem[wfull[8:0]] : 32'd0;
        @(negedge clk); #1;
        chk("ready_done", 32'(bus_if.ready), 32'd1);
        chk("we_n_done", 32'(sram_we_n), 32'd1);
        chk("rdata_done", bus_if.rdata, exp_rdata);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        chk("err_done", 32'(bus_if.err), 32'(!issued));
`endif
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        if (wr && issued && in_rng)
            chk("sram_word", sram_mem[wfull[8:0]], exp_mem[wfull[8:0]]);
    endtask

    initial begin
        bus_if.wr_en   = 1'b0;
        bus_if.rd_en   = 1'b0;
        bus_if.address = 32'd0;
        bus_if.wdata   = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("idle_ready", 32'(bus_if.ready), 32'd1);
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
            chk("idle_rdata", bus_if.rdata, 32'd0);
`ifdef SRAM_CTRL_RANGE_CHECK_EN
            chk("idle_err", 32'(bus_if.err), 32'd0);
`endif
        end

        do_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        do_op(1'b1, 1'b0, 32'd1028, 32'h12345678);
        do_op(1'b0, 1'b1, 32'd1028, 32'h0);
        chk("load_1028", bus_if.rdata, 32'h12345678);
        do_op(1'b1, 1'b1, 32'd1032, 32'd5);
        chk("both_rdata", bus_if.rdata, 32'h12345678);
        chk("both_word2", sram_mem[2], 32'd5);

        // Reset in the third ACCESS cycle of a store to 1036.
        @(negedge clk);
        bus_if.wr_en   = 1'b1;
        bus_if.address = 32'd1036;
        bus_if.wdata   = 32'hA5A5A5A5;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        bus_if.wr_en = 1'b0;
        @(negedge clk); #1;
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_rdata", bus_if.rdata, 32'd0);
        rst = 1'b0;
        exp_rdata = 32'd0;
        repeat (2) begin
            @(negedge clk); #1;
            chk("post_rst_ready", 32'(bus_if.ready), 32'd1);
            chk("post_rst_we_n", 32'(sram_we_n), 32'd1);
        end
        do_op(1'b0, 1'b1, 32'd1024, 32'h0);
        chk("reload_w0", bus_if.rdata, 32'hDEADBEEF);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
        do_op(1'b0, 1'b1, 32'd1020, 32'h0);
        chk("oor_rdata", bus_if.rdata, 32'd0);
        do_op(1'b1, 1'b0, BASE + 32'(DEP * 4), 32'hCAFEF00D);
        do_op(1'b0, 1'b1, 32'd1028, 32'h0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        w;
            logic        r;
            d = $urandom;
            if (written.size() == 0 || $urandom_range(1, 0) == 1) begin
                a = BASE + 32'($urandom_range(35, 4) * 4);
                w = 1'b1;
                r = ($urandom_range(3, 0) == 0);
            end else begin
                a = BASE + 32'(written[$urandom_range(written.size() - 1, 0)] * 4);
                w = 1'b0;
                r = 1'b1;
            end
            a[1:0] = 2'($urandom_range(3, 0));
            do_op(w, r, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits between the MEM stage of the 32-bit ARM pipeline and the external SRAM model (17-bit word address, 32-bit bidirectional DQ, active-low write enable, 30 ns read access).
- Translates single-word load/store requests into SRAM bus cycles and inserts the wait states the SRAM's access time requires.
- Drops ready to freeze the pipeline until each access completes.

Parameters:
- WAIT_CYCLES, 5: clock cycles the SRAM bus is held per access. Must be at least ceil(30 ns / Tclk) + 1.
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- DEPTH, 512: number of implemented SRAM words. Used only by the optional range check.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- wr_en  in  1  store request from MEM stage
- rd_en  in  1  load request from MEM stage
- address  in  32  byte address from ALU
- wdata  in  32  store data
- rdata  out  32  load data, registered
- ready  out  1  low = freeze pipeline
- SRAM_ADDR  out  17  SRAM word address, registered
- SRAM_WE_N  out  1  SRAM write enable, active low, registered
- SRAM_DQ  inout  32  SRAM data bus
- err  out  1  out-of-range flag; present only with the optional feature

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state IDLE, wait counter 0, rdata 0, SRAM_ADDR 0, SRAM_WE_N 1, SRAM_DQ released to high-Z, err 0.
- Reset mid-access aborts the access. SRAM_WE_N is 1 from the first edge with rst high. rdata is not updated by the aborted read.
- Address translation: word = (address - BASE_ADDR) >> 2, truncated to 17 bits. address[1:0] are ignored (word-aligned only).
- FSM states:
  - IDLE: if wr_en or rd_en is high, latch the translated address, wdata and the op, then go to ACCESS with counter = 0. wr_en has priority when both are high.
  - ACCESS: lasts exactly WAIT_CYCLES cycles. Counter increments each cycle; leave when counter == WAIT_CYCLES-1.
    - Write: SRAM_WE_N = 0 and SRAM_DQ driven with the latched wdata for all of ACCESS.
    - Read: SRAM_WE_N = 1 and SRAM_DQ high-Z; rdata <= SRAM_DQ on the final ACCESS edge.
    - SRAM_ADDR is stable for the whole state.
  - DONE: one cycle. SRAM_WE_N = 1, bus released. Next state is always IDLE; requests are not sampled in DONE.
- ready (combinational) = (state == IDLE && !wr_en && !rd_en) || state == DONE.
- Latency: a request seen in cycle 0 holds ready low in cycles 0 through WAIT_CYCLES. ready is high in cycle WAIT_CYCLES+1 (DONE), and the pipeline advances at that edge.
- A request still high in the IDLE cycle after DONE is treated as a new request (the pipeline has moved on).
- rdata holds its value until the next read completes; writes do not modify it.
- Bus rule: SRAM_DQ is driven only while state == ACCESS and the op is a write. There is never contention with the SRAM's read drive.
- Back-to-back requests: minimum spacing is WAIT_CYCLES+2 cycles per access.
- Counter width is clog2(WAIT_CYCLES)+1. WAIT_CYCLES == 0 is illegal and is caught by an elaboration check.

Optional Feature:
- Macro: SRAM_CTRL_RANGE_CHECK_EN.
- Defined:
  - If address < BASE_ADDR or the translated word >= DEPTH, the request is not issued to the SRAM. SRAM_WE_N stays 1 and the bus is not driven.
  - The FSM still runs IDLE -> ACCESS -> DONE with identical timing.
  - A dropped read returns rdata = 0.
  - err is high during DONE of that request and 0 otherwise.
- Undefined: no check is made, the address is truncated silently, and the err port does not exist.

Decomposition:
- Shared package sram_ctrl_pkg:
  - FSM state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2.
  - Constants SRAM_AW = 17, SRAM_DW = 32, default BASE_ADDR.
  - Address-translate function.
- One natural sub-module: sram_wait_counter (load/enable/terminal-count output), instantiated once.
- The FSM and bus drivers stay in the top level.

Test Plan (WAIT_CYCLES=5, 10 ns clock, SRAM model attached):
- Reset, then idle: SRAM_WE_N=1, DQ high-Z, ready=1, rdata=0 for 10 cycles with no request.
- Store wr_en, address=1024, wdata=0xDEADBEEF -> SRAM_ADDR=0, WE_N low for exactly 5 cycles, ready low 6 cycles then high 1 cycle, SRAM word 0 = 0xDEADBEEF.
- Store to 1028 with 0x12345678, then load address=1028 -> rdata=0x12345678 valid in the DONE cycle, DQ never driven by the controller during the read.
- Both wr_en and rd_en high at address=1032, wdata=5 -> write performed, SRAM word 2 = 5, rdata unchanged.
- Assert rst in the 3rd ACCESS cycle of a store to 1036 -> WE_N=1 next edge, state IDLE, ready=1 once rst drops with no request pending.
- With SRAM_CTRL_RANGE_CHECK_EN: load address=1020 -> no SRAM read, rdata=0, err=1 for exactly the DONE cycle, same 6-cycle freeze.
